// File: rtl/avalon_pio_gen_pkg.sv
// avalon_pio_pkg: shared constants for the parameterised Avalon-MM PIO.
//   - Avalon slave bus widths used by the bus interface
//   - register word addresses within the slave
//   - capture edge selectors for the EDGE_TYPE parameter
package avalon_pio_pkg;

  localparam int unsigned AVS_ADDR_W = 3;
  localparam int unsigned AVS_DATA_W = 32;

  // Register map (word addresses). Addresses 6 and 7 are reserved.
  typedef enum logic [AVS_ADDR_W-1:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_OUTSET  = 3'd4,
    ADDR_OUTCLR  = 3'd5
  } pio_addr_e;

  // Capture edge selection.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_gen_if.sv
// avalon_pio_gen_if: Avalon-MM slave bus bundle for the PIO.
//   address    word address within the slave
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, zero wait states (combinational in the slave)
interface avalon_pio_gen_if;
  import avalon_pio_pkg::*;

  logic [AVS_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [AVS_DATA_W-1:0] writedata;
  logic [AVS_DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/avalon_pio_gen_sync_edge.sv
// pio_sync_edge: input synchroniser chain plus edge detector.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   i_pins     asynchronous pin inputs
//   o_in_sync  pins after SYNC_STAGES flops
//   o_edge     one-cycle pulse per bit on the selected edge of o_in_sync
// Reusable by any input PIO; EDGE_TYPE uses the avalon_pio_pkg selectors.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_in_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_in_sync = r_sync[SYNC_STAGES-1];

  // r_prev holds last cycle's synchronised value, so the comparison below
  // is one flop past the synchroniser and never sees a metastable bit.
  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign o_edge = ~o_in_sync & r_prev;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign o_edge = o_in_sync ^ r_prev;
  end else begin : g_rise
    assign o_edge = o_in_sync & ~r_prev;
  end

endmodule

// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: parameterised Avalon-MM slave parallel I/O port.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   avs       Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   in_port   asynchronous pin inputs
//   out_port  output data register
//   oe        per-bit output enable (direction register, 1 = output)
//   irq       registered level interrupt, active-high
// Registers: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET, 5 OUTCLR;
// 6/7 reserved. Readdata is combinational from address, independent of
// chipselect; bits above DATA_WIDTH read as zero.
module avalon_pio_gen
  import avalon_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_gen_if.slave       avs,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_irqmask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic                  r_irq;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_in_sync;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_rd;
  logic                  w_unused_wdata;

  assign w_wr    = avs.chipselect & ~avs.write_n;
  assign w_wdata = avs.writedata[DATA_WIDTH-1:0];
  // Writedata bits above DATA_WIDTH are intentionally ignored.
  assign w_unused_wdata = &{1'b0, avs.writedata};

  pio_sync_edge #(
    .WIDTH       (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_pins    (in_port),
    .o_in_sync (w_in_sync),
    .o_edge    (w_edge)
  );

  // Output data: plain load, atomic set and atomic clear share one register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_OUT;
    end else if (w_wr) begin
      case (avs.address)
        ADDR_DATA:   r_data_out <= w_wdata;
        ADDR_OUTSET: r_data_out <= r_data_out | w_wdata;
        ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wdata;
        default:     r_data_out <= r_data_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir <= RESET_DIR;
    end else if (w_wr && (avs.address == ADDR_DIR)) begin
      r_dir <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr && (avs.address == ADDR_IRQMASK)) begin
      r_irqmask <= w_wdata;
    end
  end

  assign w_clr = (w_wr && (avs.address == ADDR_EDGECAP)) ? w_wdata : '0;

  // Set has priority over write-1-to-clear so an edge landing in the same
  // cycle as software's clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      r_irq     <= |(r_edgecap & r_irqmask);
    end
  end

  always_comb begin
    w_rd = '0;
    case (avs.address)
      ADDR_DATA:    w_rd = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      ADDR_DIR:     w_rd = r_dir;
      ADDR_IRQMASK: w_rd = r_irqmask;
      ADDR_EDGECAP: w_rd = r_edgecap;
      default:      w_rd = '0;
    endcase
  end

  assign avs.readdata = AVS_DATA_W'(w_rd);
  assign out_port     = r_data_out;
  assign oe           = r_dir;
  assign irq          = r_irq;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Bench for avalon_pio_gen: two instances (8-bit rising / 32-bit any-edge,
// different synchroniser depths) checked every cycle against a pin-history
// model, with directed literal checks on reset, set/clear, latency, capture,
// clear/edge collision and wide-mask interrupt.
module tb_avalon_pio_gen;

  localparam int unsigned SS [2] = '{2, 3};
  localparam int unsigned ET [2] = '{0, 2};
  localparam logic [31:0] WM [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  localparam logic [31:0] RO [2] = '{32'h0000_00A5, 32'h1234_5678};
  localparam logic [31:0] RD [2] = '{32'h0000_000F, 32'hFFFF_0000};

  logic clk;
  logic reset_n;

  logic [2:0]  b_addr [2];
  logic        b_cs   [2];
  logic        b_wn   [2];
  logic [31:0] b_wd   [2];
  logic [31:0] pins   [2];

  logic [31:0] a_out [2];
  logic [31:0] a_oe  [2];
  logic [31:0] a_rd  [2];
  logic        a_irq [2];

  logic [7:0]  out8, oe8;
  logic        irq8;
  logic [31:0] out32, oe32;
  logic        irq32;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_pio_gen_if if8 ();
  avalon_pio_gen_if if32 ();

  assign if8.address     = b_addr[0];
  assign if8.chipselect  = b_cs[0];
  assign if8.write_n     = b_wn[0];
  assign if8.writedata   = b_wd[0];
  assign if32.address    = b_addr[1];
  assign if32.chipselect = b_cs[1];
  assign if32.write_n    = b_wn[1];
  assign if32.writedata  = b_wd[1];

  avalon_pio_gen #(
    .DATA_WIDTH  (8),
    .RESET_OUT   (8'hA5),
    .RESET_DIR   (8'h0F),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (if8),
    .in_port  (pins[0][7:0]),
    .out_port (out8),
    .oe       (oe8),
    .irq      (irq8)
  );

  avalon_pio_gen #(
    .DATA_WIDTH  (32),
    .RESET_OUT   (32'h1234_5678),
    .RESET_DIR   (32'hFFFF_0000),
    .EDGE_TYPE   (2),
    .SYNC_STAGES (3)
  ) dut32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (if32),
    .in_port  (pins[1]),
    .out_port (out32),
    .oe       (oe32),
    .irq      (irq32)
  );

  assign a_out[0] = {24'h0, out8};
  assign a_oe[0]  = {24'h0, oe8};
  assign a_rd[0]  = if8.readdata;
  assign a_irq[0] = irq8;
  assign a_out[1] = out32;
  assign a_oe[1]  = oe32;
  assign a_rd[1]  = if32.readdata;
  assign a_irq[1] = irq32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // samp[k][j] is the pin value sampled j+1 clock edges ago; the DATA view
  // of the pins is the sample SYNC_STAGES edges old, "previous" one older.
  logic [31:0] samp  [2][5];
  logic [31:0] m_dout[2];
  logic [31:0] m_dir [2];
  logic [31:0] m_msk [2];
  logic [31:0] m_ec  [2];
  logic        m_irq [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 5; j++) samp[k][j] = '0;
      m_dout[k] = RO[k];
      m_dir[k]  = RD[k];
      m_msk[k]  = '0;
      m_ec[k]   = '0;
      m_irq[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] cur, old, ev, wd, clr;
    cur = samp[k][SS[k]-1];
    old = samp[k][SS[k]];
    if (ET[k] == 0)      ev = cur & ~old;
    else if (ET[k] == 1) ev = ~cur & old;
    else                 ev = cur ^ old;
    m_irq[k] = |(m_ec[k] & m_msk[k]);
    clr = '0;
    wd  = b_wd[k] & WM[k];
    if (b_cs[k] && !b_wn[k]) begin
      case (b_addr[k])
        3'd0: m_dout[k] = wd;
        3'd1: m_dir[k]  = wd;
        3'd2: m_msk[k]  = wd;
        3'd3: clr       = wd;
        3'd4: m_dout[k] = m_dout[k] | wd;
        3'd5: m_dout[k] = m_dout[k] & ~wd;
        default: ;
      endcase
    end
    m_ec[k] = (m_ec[k] & ~clr) | ev;
    for (int j = 4; j > 0; j--) samp[k][j] = samp[k][j-1];
    samp[k][0] = pins[k] & WM[k];
  endtask

  function automatic logic [31:0] model_rd(input int k, input logic [2:0] a);
    case (a)
      3'd0:    return (m_dir[k] & m_dout[k]) | (~m_dir[k] & samp[k][SS[k]-1]);
      3'd1:    return m_dir[k];
      3'd2:    return m_msk[k];
      3'd3:    return m_ec[k];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_out_port[%0d]", k), a_out[k], m_dout[k]);
      chk($sformatf("model_oe[%0d]", k), a_oe[k], m_dir[k]);
      chk($sformatf("model_irq[%0d]", k), {31'h0, a_irq[k]}, {31'h0, m_irq[k]});
      chk($sformatf("model_readdata[%0d] addr=%0d", k, b_addr[k]), a_rd[k], model_rd(k, b_addr[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the write lands on the next edge and the
  // bus is left reading the same address.
  task automatic bus_wr(input int k, input logic [2:0] a, input logic [31:0] d);
    b_addr[k] = a; b_wd[k] = d; b_cs[k] = 1'b1; b_wn[k] = 1'b0;
    tick();
    b_wn[k] = 1'b1;
  endtask

  task automatic rd_chk(input string name, input int k, input logic [2:0] a, input logic [31:0] exp);
    b_addr[k] = a; b_cs[k] = 1'b1; b_wn[k] = 1'b1;
    @(negedge clk);
    chk(name, a_rd[k], exp);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b_addr[k] = '0; b_cs[k] = 1'b0; b_wn[k] = 1'b1; b_wd[k] = '0; pins[k] = '0;
    end
    repeat (3) tick();
    pins[1] = 32'h8000_0000;
    tick();
    reset_n = 1'b1;

    // 1: reset values
    @(negedge clk);
    chk("t1_out_port", a_out[0], 32'hA5);
    chk("t1_oe", a_oe[0], 32'h0F);
    chk("t1_irq", {31'h0, a_irq[0]}, 32'h0);
    tick();
    rd_chk("t1_data_rd", 0, 3'd0, 32'h05);
    rd_chk("t1_edgecap", 0, 3'd3, 32'h0);
    rd_chk("t1_addr6", 0, 3'd6, 32'h0);
    rd_chk("t1_addr7", 0, 3'd7, 32'h0);

    // 2: load / set / clear
    bus_wr(0, 3'd1, 32'hFF);
    bus_wr(0, 3'd0, 32'h3C);
    @(negedge clk); chk("t2_load", a_out[0], 32'h3C);
    tick();
    rd_chk("t2_data_rd", 0, 3'd0, 32'h3C);
    bus_wr(0, 3'd4, 32'h81);
    @(negedge clk); chk("t2_outset", a_out[0], 32'hBD);
    tick();
    bus_wr(0, 3'd5, 32'h0C);
    @(negedge clk); chk("t2_outclr", a_out[0], 32'hB1);
    tick();
    rd_chk("t2_outset_rd", 0, 3'd4, 32'h0);

    // 3: input sampling latency
    bus_wr(0, 3'd1, 32'h00);
    b_addr[0] = 3'd0;
    pins[0] = 32'h5A;
    @(negedge clk); chk("t3_before_k", a_rd[0], 32'h00);
    tick();
    @(negedge clk); chk("t3_after_k", a_rd[0], 32'h00);
    tick();
    @(negedge clk); chk("t3_after_k1", a_rd[0], 32'h5A);
    tick();
    bus_wr(0, 3'd3, 32'hFF);

    // 4: rising capture and interrupt
    bus_wr(0, 3'd2, 32'h01);
    b_addr[0] = 3'd3;
    pins[0] = 32'h5B;
    tick(); @(negedge clk); chk("t4_ec_e1", a_rd[0], 32'h00);
    tick(); @(negedge clk); chk("t4_ec_e2", a_rd[0], 32'h00);
    tick(); @(negedge clk); chk("t4_ec_e3", a_rd[0], 32'h01);
    chk("t4_irq_e3", {31'h0, a_irq[0]}, 32'h0);
    tick(); @(negedge clk); chk("t4_irq_e4", {31'h0, a_irq[0]}, 32'h1);
    tick();
    b_wn[0] = 1'b0; b_wd[0] = 32'h01;
    tick(); b_wn[0] = 1'b1;
    @(negedge clk); chk("t4_ec_clr", a_rd[0], 32'h00);
    chk("t4_irq_hold", {31'h0, a_irq[0]}, 32'h1);
    tick(); @(negedge clk); chk("t4_irq_clr", {31'h0, a_irq[0]}, 32'h0);

    // 5: clear arriving with a new edge leaves the bit set
    tick();
    pins[0] = 32'h5A;
    repeat (5) tick();
    pins[0] = 32'h5B; tick();
    pins[0] = 32'h5A; tick();
    pins[0] = 32'h5B; tick();
    tick();
    b_addr[0] = 3'd3; b_cs[0] = 1'b1; b_wn[0] = 1'b0; b_wd[0] = 32'h01;
    tick(); b_wn[0] = 1'b1;
    @(negedge clk); chk("t5_ec_kept", a_rd[0], 32'h01);
    chk("t5_irq", {31'h0, a_irq[0]}, 32'h1);
    tick(); @(negedge clk); chk("t5_irq_next", {31'h0, a_irq[0]}, 32'h1);
    tick();

    // 6: 32-bit, any edge, masked then unmasked
    bus_wr(1, 3'd3, 32'hFFFF_FFFF);
    b_addr[1] = 3'd3;
    pins[1] = 32'h0;
    tick(); tick(); tick();
    @(negedge clk); chk("t6_ec_e3", a_rd[1], 32'h0);
    tick(); @(negedge clk); chk("t6_ec_e4", a_rd[1], 32'h8000_0000);
    chk("t6_irq_masked", {31'h0, a_irq[1]}, 32'h0);
    tick();
    bus_wr(1, 3'd2, 32'h8000_0000);
    @(negedge clk); chk("t6_irq_same", {31'h0, a_irq[1]}, 32'h0);
    tick(); @(negedge clk); chk("t6_irq_next", {31'h0, a_irq[1]}, 32'h1);
    tick();

    // random traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        b_addr[k] = 3'($urandom_range(0, 7));
        b_wd[k] = $urandom;
        if (r < 5) begin
          b_cs[k] = 1'b1; b_wn[k] = 1'b1;
        end else if (r < 8) begin
          b_cs[k] = 1'b1; b_wn[k] = 1'b0;
        end else begin
          b_cs[k] = 1'b0; b_wn[k] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) pins[k] = pins[k] ^ $urandom;
      end
      if (c == 600) reset_n = 1'b0;
      if (c == 603) reset_n = 1'b1;
      tick();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
